// File: rtl/usb_pkg.sv
// Shared constants for the USB receive path: PID codes, CRC parameters,
// PID type classes, FSM state encoding and the per-class CRC acceptance rule.
package usb_pkg;

  // PID[3:0] codes
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;
  localparam logic [3:0] PID_PRE   = 4'hC;
  localparam logic [3:0] PID_ERR   = 4'hC;
  localparam logic [3:0] PID_SPLIT = 4'h8;
  localparam logic [3:0] PID_PING  = 4'h4;

  // CRC5: x^5+x^2+1, CRC16: x^16+x^15+x^2+1 (register MSB = highest power)
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // pid[1:0] type classes
  localparam logic [1:0] PID_CLASS_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
  localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_CLASS_DATA      = 2'b11;

  localparam int MAX_BYTES_DEFAULT      = 1027;
  localparam int SYNC_MIN_ZEROS_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_EOP_WAIT
  } rx_state_t;

  // Packet-class CRC/length acceptance, evaluated on the state at EOP.
  function automatic logic crc_class_ok(input logic [1:0]  pid_class,
                                        input logic [4:0]  crc5,
                                        input logic [15:0] crc16,
                                        input logic [10:0] count);
    logic ok;
    case (pid_class)
      PID_CLASS_TOKEN:     ok = (crc5 == CRC5_RESIDUAL) && (count == 11'd2);
      PID_CLASS_DATA:      ok = (crc16 == CRC16_RESIDUAL) && (count >= 11'd2);
      PID_CLASS_HANDSHAKE: ok = (count == 11'd0);
      default:             ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Serial LSB-first CRC engine. clr loads INIT, en shifts one bit in.
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '1,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic             feedback;

  // Next CRC value: clear has priority over a shift
  always_comb begin
    crc_d    = crc_q;
    feedback = din ^ crc_q[WIDTH-1];
    if (clr) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (rst) crc_q <= INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_rx_packetizer.sv
// USB receive packetizer: SYNC detect, NRZI decode, bit unstuffing, byte
// assembly, PID check and CRC5/CRC16 validation, one bit per bit_valid strobe.
module usb_rx_packetizer
  import usb_pkg::*;
#(
  parameter int MAX_BYTES      = MAX_BYTES_DEFAULT,
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        line_k,
  input  logic        se0,
  output logic        pkt_start,
  output logic [3:0]  pid,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        pkt_end,
  output logic [10:0] byte_count,
  output logic        crc_ok,
  output logic        err_stuff,
  output logic        err_pid,
  output logic        err_align,
  output logic        err_len
);

  rx_state_t   state_q, state_d;
  logic        prev_k_q, prev_k_d;
  logic [3:0]  zcnt_q, zcnt_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [6:0]  sr_q, sr_d;
  logic        pkt_start_q, pkt_start_d;
  logic [3:0]  pid_q, pid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        pkt_end_q, pkt_end_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic        crc_ok_q, crc_ok_d;
  logic        err_stuff_q, err_stuff_d;
  logic        err_pid_q, err_pid_d;
  logic        err_align_q, err_align_d;
  logic        err_len_q, err_len_d;

  logic        nrzi_bit;
  logic [7:0]  rx_byte;
  logic        crc_clr;
  logic        crc_en;
  logic [4:0]  crc5;
  logic [15:0] crc16;

  assign nrzi_bit = (line_k == prev_k_q);
  assign rx_byte  = {nrzi_bit, sr_q};

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (nrzi_bit),
    .crc (crc5)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (nrzi_bit),
    .crc (crc16)
  );

  // Receive FSM: next state, datapath updates and output pulses
  always_comb begin
    state_d      = state_q;
    prev_k_d     = prev_k_q;
    zcnt_d       = zcnt_q;
    ones_d       = ones_q;
    bitcnt_d     = bitcnt_q;
    sr_d         = sr_q;
    pkt_start_d  = 1'b0;
    byte_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    pid_d        = pid_q;
    byte_data_d  = byte_data_q;
    byte_count_d = byte_count_q;
    crc_ok_d     = crc_ok_q;
    err_stuff_d  = err_stuff_q;
    err_pid_d    = err_pid_q;
    err_align_d  = err_align_q;
    err_len_d    = err_len_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    if (bit_valid) begin
      if (!se0) prev_k_d = line_k;
      case (state_q)
        ST_IDLE: begin
          if (!se0 && line_k) begin
            state_d = ST_SYNC;
            zcnt_d  = 4'd1;
          end
        end
        ST_SYNC: begin
          if (se0) begin
            state_d = ST_IDLE;
          end else if (!nrzi_bit) begin
            if (zcnt_q != 4'hF) zcnt_d = zcnt_q + 4'd1;
          end else if (int'(zcnt_q) >= SYNC_MIN_ZEROS) begin
            state_d  = ST_PID;
            ones_d   = 3'd0;
            bitcnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PID, ST_DATA: begin
          if (se0) begin
            // EOP: a PID cut short or a partial data byte is misaligned
            pkt_end_d = 1'b1;
            state_d   = ST_EOP_WAIT;
            if (state_q == ST_PID || bitcnt_q != 3'd0) err_align_d = 1'b1;
          end else if (ones_q == 3'd6) begin
            // Bit after six ones must be a stuffed zero, which is dropped
            if (nrzi_bit) begin
              err_stuff_d = 1'b1;
              pkt_end_d   = 1'b1;
              state_d     = ST_EOP_WAIT;
            end else begin
              ones_d = 3'd0;
            end
          end else begin
            ones_d   = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            bitcnt_d = bitcnt_q + 3'd1;
            sr_d     = {nrzi_bit, sr_q[6:1]};
            if (state_q == ST_DATA) crc_en = 1'b1;
            if (bitcnt_q == 3'd7) begin
              if (state_q == ST_PID) begin
                if (rx_byte[7:4] == ~rx_byte[3:0]) begin
                  pkt_start_d  = 1'b1;
                  pid_d        = rx_byte[3:0];
                  byte_count_d = 11'd0;
                  crc_ok_d     = 1'b0;
                  err_stuff_d  = 1'b0;
                  err_pid_d    = 1'b0;
                  err_align_d  = 1'b0;
                  err_len_d    = 1'b0;
                  crc_clr      = 1'b1;
                  state_d      = ST_DATA;
                end else begin
                  err_pid_d = 1'b1;
                  pkt_end_d = 1'b1;
                  state_d   = ST_EOP_WAIT;
                end
              end else if (int'(byte_count_q) >= MAX_BYTES) begin
                err_len_d = 1'b1;
                pkt_end_d = 1'b1;
                state_d   = ST_EOP_WAIT;
              end else begin
                byte_valid_d = 1'b1;
                byte_data_d  = rx_byte;
                byte_count_d = byte_count_q + 11'd1;
              end
            end
          end
        end
        ST_EOP_WAIT: begin
          if (!se0) begin
            state_d  = ST_IDLE;
            prev_k_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Packet verdict is frozen together with the end pulse
    if (pkt_end_d) begin
      crc_ok_d = !(err_stuff_d || err_pid_d || err_align_d || err_len_d) &&
                 crc_class_ok(pid_q[1:0], crc5, crc16, byte_count_q);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_k_q     <= 1'b0;
      zcnt_q       <= 4'd0;
      ones_q       <= 3'd0;
      bitcnt_q     <= 3'd0;
      sr_q         <= 7'd0;
      pkt_start_q  <= 1'b0;
      pid_q        <= 4'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      byte_count_q <= 11'd0;
      crc_ok_q     <= 1'b0;
      err_stuff_q  <= 1'b0;
      err_pid_q    <= 1'b0;
      err_align_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_k_q     <= prev_k_d;
      zcnt_q       <= zcnt_d;
      ones_q       <= ones_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      pkt_start_q  <= pkt_start_d;
      pid_q        <= pid_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      pkt_end_q    <= pkt_end_d;
      byte_count_q <= byte_count_d;
      crc_ok_q     <= crc_ok_d;
      err_stuff_q  <= err_stuff_d;
      err_pid_q    <= err_pid_d;
      err_align_q  <= err_align_d;
      err_len_q    <= err_len_d;
    end
  end

  assign pkt_start  = pkt_start_q;
  assign pid        = pid_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_end    = pkt_end_q;
  assign byte_count = byte_count_q;
  assign crc_ok     = crc_ok_q;
  assign err_stuff  = err_stuff_q;
  assign err_pid    = err_pid_q;
  assign err_align  = err_align_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_usb_rx_packetizer.sv
// Bench for usb_rx_packetizer: encodes byte lists onto the line (SYNC, NRZI,
// bit stuffing, EOP), predicts the event stream from packet-level rules and
// compares every start/byte/end pulse against the prediction.
module tb_usb_rx_packetizer;

  localparam int MAXB = 1027;

  logic        clk;
  logic        rst;
  logic        bit_valid;
  logic        line_k;
  logic        se0;
  logic        pkt_start;
  logic [3:0]  pid;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        pkt_end;
  logic [10:0] byte_count;
  logic        crc_ok;
  logic        err_stuff;
  logic        err_pid;
  logic        err_align;
  logic        err_len;

  usb_rx_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .line_k     (line_k),
    .se0        (se0),
    .pkt_start  (pkt_start),
    .pid        (pid),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .pkt_end    (pkt_end),
    .byte_count (byte_count),
    .crc_ok     (crc_ok),
    .err_stuff  (err_stuff),
    .err_pid    (err_pid),
    .err_align  (err_align),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected events; packed as in the monitor below
  int q_start[$];
  int q_byte[$];
  int q_end[$];

  logic [7:0] tx_bytes[$];
  logic       cur_k;

  // Persistent model view of the held outputs
  logic [3:0] m_pid;
  logic [4:0] m_stat;   // {crc_ok, err_stuff, err_pid, err_align, err_len}
  int         m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference CRCs (reflected, table-free) ----------------
  function automatic logic [4:0] crc5_11(input logic [10:0] d);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = ((c[0] ^ d[i]) != 1'b0) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_bytes(input int first, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'h00, tx_bytes[first + k]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- packet-level model ----------------
  task automatic push_end();
    q_end.push_back((int'(m_pid) << 16) | (m_cnt << 5) | int'(m_stat));
  endtask

  task automatic model_packet(input int nbits, input bit eop);
    logic [7:0] pb, b1, b2;
    logic [15:0] c16;
    logic ok;
    int ndata, rem;
    pb = tx_bytes[0];
    if (pb[7:4] != ~pb[3:0]) begin
      m_stat[2] = 1'b1;
      m_stat[4] = 1'b0;
      push_end();
      return;
    end
    m_pid  = pb[3:0];
    m_stat = 5'b0;
    m_cnt  = 0;
    q_start.push_back(int'(m_pid));
    ndata = (nbits - 8) / 8;
    rem   = (nbits - 8) % 8;
    for (int k = 0; k < ndata; k++) begin
      if (m_cnt == MAXB) begin
        m_stat[0] = 1'b1;
        push_end();
        return;
      end
      m_cnt++;
      q_byte.push_back((m_cnt << 8) | int'(tx_bytes[k + 1]));
    end
    if (!eop) return;
    if (rem != 0) begin
      m_stat[1] = 1'b1;
      push_end();
      return;
    end
    case (m_pid[1:0])
      2'b01: begin
        b1 = tx_bytes[1];
        b2 = tx_bytes[2];
        ok = (ndata == 2) && (crc5_11({b2[2:0], b1}) == b2[7:3]);
      end
      2'b11: begin
        ok = 1'b0;
        if (ndata >= 2) begin
          c16 = crc16_bytes(1, ndata - 2);
          ok  = (c16 == {tx_bytes[ndata], tx_bytes[ndata - 1]});
        end
      end
      2'b10:   ok = (ndata == 0);
      default: ok = 1'b1;
    endcase
    m_stat[4] = ok;
    push_end();
  endtask

  // ---------------- compare process ----------------
  int mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_start) begin
        if (q_start.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pkt_start: got pid 0x%0h, expected no start", pid);
        end else begin
          mon_e = q_start.pop_front();
          check("pkt_start_pid", 32'(pid), mon_e);
        end
      end
      if (byte_valid) begin
        if (q_byte.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte_valid: got byte 0x%0h, expected no byte", byte_data);
        end else begin
          mon_e = q_byte.pop_front();
          check("byte_count_data", 32'({byte_count, byte_data}), mon_e);
        end
      end
      if (pkt_end) begin
        if (q_end.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pkt_end: got status 0x%0h, expected no end",
                   {crc_ok, err_stuff, err_pid, err_align, err_len});
        end else begin
          mon_e = q_end.pop_front();
          check("pkt_end_pid_count_status",
                32'({pid, byte_count, crc_ok, err_stuff, err_pid, err_align, err_len}), mon_e);
        end
      end
    end
  end

  // ---------------- line driver ----------------
  task automatic drive(input logic k, input logic s);
    @(posedge clk); #1;
    bit_valid = 1'b1;
    line_k    = k;
    se0       = s;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic tx_nrzi(input logic b);
    if (!b) cur_k = ~cur_k;
    drive(cur_k, 1'b0);
  endtask

  task automatic tx_eop();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    cur_k = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
  endtask

  // Sends SYNC (sync_zeros zeros then a 1) and nbits of tx_bytes, stuffing
  // after six ones. corrupt=n turns the n-th stuff bit into a 1 and ends.
  task automatic send(input int nbits, input int sync_zeros, input int corrupt, input bit eop);
    int ones = 0;
    int nstuff = 0;
    logic [7:0] cur;
    logic b;
    for (int i = 0; i < sync_zeros; i++) tx_nrzi(1'b0);
    tx_nrzi(1'b1);
    for (int i = 0; i < nbits; i++) begin
      cur = tx_bytes[i / 8];
      b   = cur[i % 8];
      tx_nrzi(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        ones = 0;
        nstuff++;
        if (nstuff == corrupt) begin
          tx_nrzi(1'b1);
          tx_eop();
          return;
        end
        tx_nrzi(1'b0);
      end
    end
    if (eop) tx_eop();
  endtask

  task automatic load(input logic [87:0] v, input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(v[8 * (n - 1 - i) +: 8]);
  endtask

  task automatic drained(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_starts_left"}, 32'(q_start.size()), 32'd0);
    check({tag, "_bytes_left"},  32'(q_byte.size()),  32'd0);
    check({tag, "_ends_left"},   32'(q_end.size()),   32'd0);
  endtask

  task automatic run(input string tag, input int nbits, input int sync_zeros);
    model_packet(nbits, 1'b1);
    send(nbits, sync_zeros, 0, 1'b1);
    drained(tag);
    $display("packet %s: %0d bytes queued, %0d bits sent", tag, tx_bytes.size(), nbits);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] c16_tmp;

  initial begin
    rst = 1'b1; bit_valid = 1'b0; line_k = 1'b0; se0 = 1'b0; cur_k = 1'b0;
    m_pid = 4'd0; m_stat = 5'd0; m_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_pulses", 32'({pkt_start, byte_valid, pkt_end}), 32'd0);
    check("rst_pid_data_count", 32'({pid, byte_data, byte_count}), 32'd0);
    check("rst_status", 32'({crc_ok, err_stuff, err_pid, err_align, err_len}), 32'd0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0);

    // Model pins
    check("pin_crc5_zero_token", 32'(crc5_11(11'h000)), 32'h02);
    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    check("pin_crc16_setup_req", 32'(crc16_bytes(1, 8)), 32'h94DD);

    // SETUP token, full SYNC
    load(88'h2D0010, 3);
    run("setup", 24, 7);
    check("setup_pid", 32'(pid), 32'hD);
    check("setup_count", 32'(byte_count), 32'd2);
    check("setup_last_byte", 32'(byte_data), 32'h10);
    check("setup_status", 32'({crc_ok, err_stuff, err_pid, err_align, err_len}), 32'h10);

    // DATA0 with correct CRC16
    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    run("data0", 88, 7);
    check("data0_count", 32'(byte_count), 32'd10);
    check("data0_crc_ok", 32'(crc_ok), 32'd1);

    // DATA0 with one payload bit flipped
    load({8'hC3, 8'h81, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    run("data0_bad", 88, 7);
    check("data0_bad_crc_ok", 32'(crc_ok), 32'd0);

    // DATA1 FF FF with bench-computed CRC; exercises stuffing
    load(88'h4BFFFF, 3);
    c16_tmp = crc16_bytes(1, 2);
    tx_bytes.push_back(c16_tmp[7:0]);
    tx_bytes.push_back(c16_tmp[15:8]);
    run("data1_stuffed", 40, 7);
    check("data1_crc_ok", 32'(crc_ok), 32'd1);
    check("data1_count", 32'(byte_count), 32'd4);

    // Same packet with the first stuffed zero replaced by a one
    q_start.push_back(32'hB);
    m_pid = 4'hB; m_cnt = 0; m_stat = 5'b01000;
    push_end();
    send(40, 7, 1, 1'b1);
    drained("data1_stuff_err");
    $display("packet data1_stuff_err: stuff bit 1 corrupted");
    check("stuff_err_flag", 32'(err_stuff), 32'd1);
    check("stuff_err_crc_ok", 32'(crc_ok), 32'd0);

    // ACK handshake
    load(88'hD2, 1);
    run("ack", 8, 7);
    check("ack_pid", 32'(pid), 32'h2);
    check("ack_count_crc", 32'({byte_count, crc_ok}), 32'd1);

    // Bad PID check bits
    load(88'h2E, 1);
    run("bad_pid", 8, 7);
    check("bad_pid_flag", 32'(err_pid), 32'd1);

    // SE0 after PID plus 13 data bits
    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    run("align", 21, 7);
    check("align_flag_count", 32'({err_align, byte_count}), 32'h801);

    // Truncated SYNC (KJKK)
    load(88'h2D0010, 3);
    run("short_sync", 24, 3);
    check("short_sync_status", 32'({pid, crc_ok}), 32'h1B);

    // Reset in the middle of a DATA packet
    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    model_packet(28, 1'b0);
    send(28, 7, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pid = 4'd0; m_stat = 5'd0; m_cnt = 0;
    cur_k = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    drained("mid_rst");
    $display("packet mid_rst: reset after 28 bits");
    check("mid_rst_pid_count", 32'({pid, byte_count}), 32'd0);
    load(88'h2D0010, 3);
    run("after_rst", 24, 7);
    check("after_rst_crc_ok", 32'(crc_ok), 32'd1);

    // Over-long DATA0: 1028 bytes after the PID
    tx_bytes.delete();
    tx_bytes.push_back(8'hC3);
    for (int i = 0; i < 1028; i++) tx_bytes.push_back(8'(i));
    run("too_long", 8 * 1029, 7);
    check("too_long_flags", 32'({err_len, crc_ok, byte_count}), 32'h1403);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
